// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap sequencer and CSR store for an RV32I core (M-mode only).
//   Arbitrates synchronous exceptions, interrupts and mret, drains the
//   pipeline, updates mstatus/mepc/mcause/mtval and issues a one-cycle PC
//   redirect to fetch. Also owns the CSR read/write port for these registers.
//
// Ports
//   clk_i           core clock
//   rst_i           asynchronous reset, active-high
//   irq_ext_i       machine external interrupt (level, asynchronous)
//   irq_timer_i     machine timer interrupt (level, asynchronous)
//   irq_sw_i        machine software interrupt (level, asynchronous)
//   exc_valid_i     synchronous exception at commit
//   exc_code_i      exception cause code
//   exc_pc_i        PC of the faulting instruction
//   exc_tval_i      trap value for mtval
//   mret_valid_i    mret at commit
//   commit_pc_i     PC of the oldest uncommitted instruction (interrupt mepc)
//   pipe_drained_i  pipeline empty after flush
//   csr_wen_i       CSR write strobe
//   csr_addr_i      CSR address
//   csr_wdata_i     CSR write data (already read-modify-written upstream)
//   csr_rdata_o     CSR read data, combinational from csr_addr_i
//   flush_req_o     kill/drain pipeline
//   redirect_vld_o  one-cycle PC redirect strobe
//   redirect_pc_o   redirect target
//   trap_busy_o     high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_sw_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            pipe_drained_i,
  input  logic            csr_wen_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            flush_req_o,
  output logic            redirect_vld_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_busy_o
);

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Interrupt cause codes
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    K_EXC,
    K_INT,
    K_MRET
  } kind_e;

  // ---------------------------------------------------------------------------
  // Interrupt synchronizers. Index 2 = external, 1 = timer, 0 = software.
  // ---------------------------------------------------------------------------
  logic [2:0] irq_raw;
  logic [2:0] irq_sync;

  assign irq_raw = {irq_ext_i, irq_timer_i, irq_sw_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw[gi]};
        end
      end
      assign irq_sync[gi] = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and CSR registers
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [3:0]      code_q, code_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]      mie_en_q, mie_en_d;     // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      kind_q         <= K_EXC;
      code_q         <= '0;
      pc_q           <= '0;
      tval_q         <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_en_q       <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      code_q         <= code_d;
      pc_q           <= pc_d;
      tval_q         <= tval_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_en_q       <= mie_en_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt pending and priority (MEI > MSI > MTI)
  // ---------------------------------------------------------------------------
  logic [2:0] irq_active;
  logic       int_pend;
  logic [3:0] int_code;

  assign irq_active = mie_en_q & irq_sync;
  assign int_pend   = mstatus_mie_q & (|irq_active);
  assign int_code   = irq_active[2] ? CODE_MEI :
                      irq_active[0] ? CODE_MSI : CODE_MTI;

  // Trap target: vectored mode only offsets interrupts.
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  assign trap_base   = mtvec_q & ~XLEN'(3);
  assign trap_target = (mtvec_q[0] && kind_q == K_INT)
                       ? trap_base + {{(XLEN-6){1'b0}}, code_q, 2'b00}
                       : trap_base;

  // ---------------------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[12:11] = 2'b11;
        csr_rdata_o[7]     = mstatus_mpie_q;
        csr_rdata_o[3]     = mstatus_mie_q;
      end
      CSR_MISA:     csr_rdata_o = MISA_VALUE;
      CSR_MSTATUSH: csr_rdata_o = '0;
      CSR_MIE: begin
        csr_rdata_o[11] = mie_en_q[2];
        csr_rdata_o[7]  = mie_en_q[1];
        csr_rdata_o[3]  = mie_en_q[0];
      end
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MTVAL:    csr_rdata_o = mtval_q;
      CSR_MIP: begin
        csr_rdata_o[11] = irq_sync[2];
        csr_rdata_o[7]  = irq_sync[1];
        csr_rdata_o[3]  = irq_sync[0];
      end
      default:      csr_rdata_o = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state, CSR updates and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    code_d         = code_q;
    pc_d           = pc_q;
    tval_d         = tval_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_en_d       = mie_en_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    flush_req_o    = 1'b0;
    redirect_vld_o = 1'b0;
    redirect_pc_o  = '0;
    trap_busy_o    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // Software CSR writes only land while idle; the interrupt decision
        // below still uses the pre-write register values.
        if (csr_wen_i) begin
          case (csr_addr_i)
            CSR_MSTATUS: begin
              mstatus_mie_d  = csr_wdata_i[3];
              mstatus_mpie_d = csr_wdata_i[7];
            end
            CSR_MIE:      mie_en_d   = {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
            CSR_MTVEC:    mtvec_d    = csr_wdata_i & ~XLEN'(2);
            CSR_MSCRATCH: mscratch_d = csr_wdata_i;
            CSR_MEPC:     mepc_d     = csr_wdata_i & ~XLEN'(3);
            CSR_MCAUSE:   mcause_d   = csr_wdata_i;
            CSR_MTVAL:    mtval_d    = csr_wdata_i;
            default: ;
          endcase
        end

        if (exc_valid_i) begin
          kind_d  = K_EXC;
          code_d  = exc_code_i;
          pc_d    = exc_pc_i;
          tval_d  = exc_tval_i;
          state_d = ST_DRAIN;
        end else if (int_pend) begin
          kind_d  = K_INT;
          code_d  = int_code;
          pc_d    = commit_pc_i;
          tval_d  = '0;
          state_d = ST_DRAIN;
        end else if (mret_valid_i) begin
          kind_d  = K_MRET;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        flush_req_o = 1'b1;
        if (pipe_drained_i) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        redirect_vld_o = 1'b1;
        state_d        = ST_IDLE;
        if (kind_q == K_MRET) begin
          redirect_pc_o  = mepc_q;
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
        end else begin
          redirect_pc_o  = trap_target;
          mepc_d         = pc_q & ~XLEN'(3);
          mcause_d       = {(kind_q == K_INT), {(XLEN-5){1'b0}}, code_q};
          mtval_d        = tval_q;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Directed-vector bench for trap_ctrl. Stimulus pushes each expected redirect
//   target into a queue; a monitor pops and compares whenever redirect_vld_o
//   is seen. CSR side effects are checked by direct reads.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        irq_ext_i, irq_timer_i, irq_sw_i;
  logic        exc_valid_i;
  logic [3:0]  exc_code_i;
  logic [31:0] exc_pc_i, exc_tval_i;
  logic        mret_valid_i;
  logic [31:0] commit_pc_i;
  logic        pipe_drained_i;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        flush_req_o, redirect_vld_o, trap_busy_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  trap_ctrl #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .irq_ext_i      (irq_ext_i),
    .irq_timer_i    (irq_timer_i),
    .irq_sw_i       (irq_sw_i),
    .exc_valid_i    (exc_valid_i),
    .exc_code_i     (exc_code_i),
    .exc_pc_i       (exc_pc_i),
    .exc_tval_i     (exc_tval_i),
    .mret_valid_i   (mret_valid_i),
    .commit_pc_i    (commit_pc_i),
    .pipe_drained_i (pipe_drained_i),
    .csr_wen_i      (csr_wen_i),
    .csr_addr_i     (csr_addr_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .flush_req_o    (flush_req_o),
    .redirect_vld_o (redirect_vld_o),
    .redirect_pc_o  (redirect_pc_o),
    .trap_busy_o    (trap_busy_o)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (redirect_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect: got 0x%08h expected no redirect", redirect_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("redirect_pc", redirect_pc_o, mon_exp);
        $display("redirect pc=0x%08h expected=0x%08h", redirect_pc_o, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wen_i   = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    tick();
    csr_wen_i   = 1'b0;
    $display("csr write addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic csr_check(input string name, input logic [11:0] a, input logic [31:0] e);
    csr_addr_i = a;
    #1;
    check(name, csr_rdata_o, e);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (trap_busy_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'b0, trap_busy_o}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (trap_busy_o !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'b0, trap_busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
    exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_tval_i = 0;
    mret_valid_i = 0; commit_pc_i = 0; pipe_drained_i = 0;
    csr_wen_i = 0; csr_addr_i = 0; csr_wdata_i = 0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_flush", {31'b0, flush_req_o}, 32'd0);
    check("rst_redirect_vld", {31'b0, redirect_vld_o}, 32'd0);
    check("rst_busy", {31'b0, trap_busy_o}, 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    csr_check("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_check("rst_mtvec", 12'h305, 32'h0);
    csr_check("rst_misa", 12'h301, 32'h4000_0100);
    rst_i = 1'b0;
    tick();
    csr_check("rst_mip", 12'h344, 32'h0);
    $display("reset done");

    // ---------------- 1: exception, minimum latency ----------------
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'h0000_0008);          // MIE = 1, no interrupts enabled
    csr_check("t1_mstatus_pre", 12'h300, 32'h0000_1808);
    exp_q.push_back(32'h0000_0100);
    exc_valid_i = 1; exc_code_i = 4'd2; exc_pc_i = 32'h80; exc_tval_i = 32'hDEAD;
    tick();                                      // cycle N accepted
    exc_valid_i = 0;
    check("t1_flush", {31'b0, flush_req_o}, 32'd1);
    check("t1_busy", {31'b0, trap_busy_o}, 32'd1);
    check("t1_no_early_redirect", {31'b0, redirect_vld_o}, 32'd0);
    pipe_drained_i = 1;
    tick();                                      // N+2
    check("t1_redirect_at_n2", {31'b0, redirect_vld_o}, 32'd1);
    check("t1_flush_off_commit", {31'b0, flush_req_o}, 32'd0);
    tick();
    check("t1_idle", {31'b0, trap_busy_o}, 32'd0);
    csr_check("t1_mepc", 12'h341, 32'h80);
    csr_check("t1_mcause", 12'h342, 32'h2);
    csr_check("t1_mtval", 12'h343, 32'hDEAD);
    csr_check("t1_mstatus", 12'h300, 32'h0000_1880);
    $display("test1 exception done");

    // ---------------- 2: vectored timer interrupt ----------------
    tick();
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    commit_pc_i = 32'h1234_5670;
    exp_q.push_back(32'h0000_021C);
    irq_timer_i = 1;
    tick();
    tick();                                      // through both sync stages
    check("t2_not_yet_busy", {31'b0, trap_busy_o}, 32'd0);
    csr_check("t2_mip", 12'h344, 32'h0000_0080);
    wait_busy("t2_busy");
    wait_idle("t2_idle");
    csr_check("t2_mcause", 12'h342, 32'h8000_0007);
    csr_check("t2_mepc", 12'h341, 32'h1234_5670);
    csr_check("t2_mtval", 12'h343, 32'h0);
    irq_timer_i = 0;
    repeat (3) tick();
    $display("test2 timer interrupt done");

    // ---------------- 3: priority + mret re-take ----------------
    csr_write(12'h304, 32'h0000_0888);
    csr_write(12'h300, 32'h0000_0008);
    commit_pc_i = 32'h0000_3000;
    exp_q.push_back(32'h0000_022C);              // 0x200 + 4*11
    irq_ext_i = 1; irq_timer_i = 1; irq_sw_i = 1;
    wait_busy("t3_busy");
    wait_idle("t3_idle");
    csr_check("t3_mcause", 12'h342, 32'h8000_000B);
    exp_q.push_back(32'h0000_3000);              // mret -> mepc
    exp_q.push_back(32'h0000_022C);              // immediate re-take
    mret_valid_i = 1;
    tick();
    mret_valid_i = 0;
    wait_busy("t3_mret_busy");
    wait_idle("t3_mret_idle");
    csr_check("t3_mstatus_after_mret", 12'h300, 32'h0000_1888);
    tick();
    check("t3_retake_immediate", {31'b0, trap_busy_o}, 32'd1);
    wait_idle("t3_retake_idle");
    csr_check("t3_retake_mcause", 12'h342, 32'h8000_000B);
    csr_check("t3_mip", 12'h344, 32'h0000_0888);
    irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
    repeat (3) tick();
    $display("test3 priority/retake done");

    // ---------------- 4: exception beats interrupt and mret ----------------
    csr_write(12'h304, 32'h0000_0008);
    irq_sw_i = 1;
    repeat (3) tick();
    csr_write(12'h300, 32'h0000_0008);           // int_pend now true
    exp_q.push_back(32'h0000_0200);              // exception: no vector offset
    exc_valid_i = 1; exc_code_i = 4'd3; exc_pc_i = 32'h500; exc_tval_i = 32'h7;
    mret_valid_i = 1;
    tick();
    exc_valid_i = 0; mret_valid_i = 0;
    wait_idle("t4_idle");
    csr_check("t4_mcause", 12'h342, 32'h3);
    csr_check("t4_mepc", 12'h341, 32'h500);
    csr_check("t4_mtval", 12'h343, 32'h7);
    csr_check("t4_mstatus", 12'h300, 32'h0000_1880);
    irq_sw_i = 0;
    tick();
    check("t4_mret_dropped", {31'b0, trap_busy_o}, 32'd0);
    repeat (3) tick();
    $display("test4 arbitration done");

    // ---------------- 5: mret to 0x444, mepc alignment ----------------
    csr_write(12'h341, 32'h0000_0444);
    csr_write(12'h300, 32'h0000_0080);           // MPIE = 1, MIE = 0
    exp_q.push_back(32'h0000_0444);
    mret_valid_i = 1;
    tick();
    mret_valid_i = 0;
    wait_idle("t5_idle");
    csr_check("t5_mstatus", 12'h300, 32'h0000_1888);
    csr_write(12'h341, 32'h0000_0447);
    csr_check("t5_mepc_align", 12'h341, 32'h0000_0444);
    csr_write(12'h305, 32'h0000_0203);
    csr_check("t5_mtvec_bit1", 12'h305, 32'h0000_0201);
    csr_write(12'h301, 32'hFFFF_FFFF);
    csr_check("t5_misa_ro", 12'h301, 32'h4000_0100);
    csr_check("t5_unmapped", 12'h7C0, 32'h0);
    csr_check("t5_mstatush", 12'h310, 32'h0);
    $display("test5 mret done");

    // ---------------- 6: reset during DRAIN ----------------
    tick();
    pipe_drained_i = 0;
    exc_valid_i = 1; exc_code_i = 4'd5; exc_pc_i = 32'h900; exc_tval_i = 32'h11;
    tick();
    exc_valid_i = 0;
    repeat (3) tick();
    check("t6_flush_held", {31'b0, flush_req_o}, 32'd1);
    #2;
    rst_i = 1'b1;                                 // mid-cycle, away from the edge
    #1;
    check("t6_flush_async", {31'b0, flush_req_o}, 32'd0);
    check("t6_busy_async", {31'b0, trap_busy_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    // The aborted trap must not land: registers hold reset values, not 0x900/5.
    csr_check("t6_mepc", 12'h341, 32'h0);
    csr_check("t6_mcause", 12'h342, 32'h0);
    csr_check("t6_mtvec", 12'h305, 32'h0);
    csr_check("t6_mstatus", 12'h300, 32'h0000_1800);
    check("t6_idle", {31'b0, trap_busy_o}, 32'd0);
    // Sequencer is usable again after reset.
    pipe_drained_i = 1;
    exp_q.push_back(32'h0000_0000);
    exc_valid_i = 1; exc_code_i = 4'd4; exc_pc_i = 32'h40; exc_tval_i = 32'h0;
    tick();
    exc_valid_i = 0;
    wait_idle("t6_post_idle");
    csr_check("t6_post_mcause", 12'h342, 32'h4);
    csr_check("t6_post_mepc", 12'h341, 32'h40);
    $display("test6 reset-in-drain done");

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
